// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-addressed data memory without byte enables.
// Sub-word stores become a read-modify-write of the containing word.
module load_store_unit #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned WORDS     = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

  localparam logic [63:0] END_ADDR = 64'(BASE_ADDR) + 64'(WORDS) * 64'd4;

  state_t      state_q, state_d;
  logic        wr_q, err_q;
  logic [2:0]  f3_q;
  logic [29:0] word_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q, merge_q, rdata_q;

  logic        accept, misaligned, out_of_range, illegal, req_err;
  logic [31:0] req_off, shifted, load_val, lane_mask, lane_data, merged;
  logic [4:0]  shamt;

  assign accept  = req_valid && (state_q == IDLE);
  assign req_off = req_addr - BASE_ADDR;

  always_comb begin
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = (req_addr < BASE_ADDR) || (64'(req_addr) >= END_ADDR);
    illegal      = req_write ? (req_funct3 > 3'd2)
                             : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
    req_err      = misaligned || out_of_range || illegal;
  end

  // Lane is taken from the memory-relative offset so word and lane stay consistent.
  always_comb begin
    shamt   = {lane_q, 3'b000};
    shifted = mem_read_data >> shamt;
    unique case (f3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'h0, shifted[7:0]};
      3'b101:  load_val = {16'h0, shifted[15:0]};
      default: load_val = mem_read_data;
    endcase
    lane_mask = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << shamt;
    lane_data = (f3_q[0] ? {16'h0, wdata_q[15:0]} : {24'h0, wdata_q[7:0]}) << shamt;
    merged    = (merge_q & ~lane_mask) | lane_data;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = req_err ? RESP : ACCESS;
      ACCESS:  state_d = (wr_q && (f3_q[1:0] != 2'b10)) ? MERGE : RESP;
      MERGE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready        = (state_q == IDLE);
    rsp_valid        = (state_q == RESP);
    rsp_error        = rsp_valid && err_q;
    rsp_rdata        = rdata_q;
    mem_address      = {word_q, 2'b00};
    mem_write_enable = rst_n && (((state_q == ACCESS) && wr_q && (f3_q == 3'b010)) ||
                                 (state_q == MERGE));
    mem_write_data   = '0;
    if (mem_write_enable) mem_write_data = (state_q == MERGE) ? merged : wdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      word_q  <= '0;
      lane_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_q    <= req_write;
        err_q   <= req_err;
        f3_q    <= req_funct3;
        word_q  <= req_off[31:2];
        lane_q  <= req_off[1:0];
        wdata_q <= req_wdata;
        rdata_q <= '0;
      end else if (state_q == ACCESS) begin
        if (wr_q) merge_q <= mem_read_data;
        else      rdata_q <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, reset-mid-RMW sequence,
// and randomized requests against an arithmetic reference model of the memory.
module tb_load_store_unit;
  localparam int unsigned WORDS = 64;
  localparam int unsigned AW    = $clog2(WORDS);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable;

  load_store_unit #(.BASE_ADDR(32'h0000_0000), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [WORDS];
  logic [31:0] ref_mem [WORDS];
  int checks = 0, errors = 0;
  int wr_count = 0, rsp_count = 0, viol = 0;

  assign mem_read_data = mem[mem_address[AW+1:2]];

  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem[mem_address[AW+1:2]] <= mem_write_data;
      wr_count++;
    end
  end

  always @(negedge clk) begin
    if (rsp_valid) rsp_count++;
    if (mem_write_enable && (!rst_n || mem_address[1:0] != 2'b00)) viol++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: what the request should do to an ideal byte-addressed memory.
  task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic er,
                       output int lat, output int nw);
    longint unsigned addr = a;
    int unsigned size, sh, idx;
    logic [31:0] word, v, mask;
    bit illegal, misal, oor;
    size    = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    illegal = w ? (f3 > 2) : (f3 == 3 || f3 == 6 || f3 == 7);
    misal   = !illegal && (addr % size != 0);
    oor     = addr >= 4 * WORDS;
    rd = 0; er = 0; nw = 0; lat = 2;
    if (illegal || misal || oor) begin
      er = 1; lat = 1;
      return;
    end
    idx  = int'(addr / 4);
    sh   = int'(addr % 4) * 8;
    word = ref_mem[idx];
    if (!w) begin
      v = word >> sh;
      case (f3)
        3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
        3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
        3'd4: v = v & 32'hFF;
        3'd5: v = v & 32'hFFFF;
        default: v = word;
      endcase
      rd = v;
    end else begin
      nw = 1;
      if (f3 == 3'd2) ref_mem[idx] = d;
      else begin
        lat  = 3;
        mask = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << sh;
        ref_mem[idx] = (word & ~mask) | ((d << sh) & mask);
      end
    end
  endtask

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic er,
                        output int lat, output int nw);
    int w0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    w0 = wr_count;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; rd = 'x; er = 1'bx;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (rsp_valid) begin lat = k; rd = rsp_rdata; er = rsp_error; end
    end
    nw = wr_count - w0;
    if (lat == 0) chk("rsp_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    chk("rsp_one_cycle", {30'd0, rsp_valid, req_ready}, 32'd1);
  endtask

  typedef struct {
    logic w; logic [2:0] f3; logic [31:0] a, d, rd; logic er; int lat;
  } vec_t;
  vec_t tbl[$];

  initial begin
    logic [31:0] rd, erd;
    logic er, eer;
    int lat, elat, nw, enw, w0, r0, bad;

    for (int i = 0; i < WORDS; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we", {31'd0, mem_write_enable}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp", {30'd0, rsp_valid, rsp_error}, 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);

    tbl.push_back('{1'b1, 3'd2, 32'h08, 32'hDEADBEEF, 32'h0, 1'b0, 2});
    tbl.push_back('{1'b0, 3'd2, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0, 2});
    tbl.push_back('{1'b1, 3'd0, 32'h09, 32'h55, 32'h0, 1'b0, 3});
    tbl.push_back('{1'b0, 3'd2, 32'h08, 32'h0, 32'hDEAD55EF, 1'b0, 2});
    tbl.push_back('{1'b0, 3'd0, 32'h09, 32'h0, 32'h00000055, 1'b0, 2});
    tbl.push_back('{1'b0, 3'd0, 32'h0B, 32'h0, 32'hFFFFFFDE, 1'b0, 2});
    tbl.push_back('{1'b0, 3'd4, 32'h0B, 32'h0, 32'h000000DE, 1'b0, 2});
    tbl.push_back('{1'b0, 3'd1, 32'h0A, 32'h0, 32'hFFFFDEAD, 1'b0, 2});
    tbl.push_back('{1'b0, 3'd5, 32'h0A, 32'h0, 32'h0000DEAD, 1'b0, 2});
    tbl.push_back('{1'b1, 3'd1, 32'h0E, 32'h0000BEEF, 32'h0, 1'b0, 3});
    tbl.push_back('{1'b0, 3'd2, 32'h0C, 32'h0, 32'hBEEF0000, 1'b0, 2});
    tbl.push_back('{1'b0, 3'd2, 32'h06, 32'h0, 32'h0, 1'b1, 1});
    tbl.push_back('{1'b1, 3'd1, 32'h01, 32'h1234, 32'h0, 1'b1, 1});
    tbl.push_back('{1'b0, 3'd2, 32'h100, 32'h0, 32'h0, 1'b1, 1});
    tbl.push_back('{1'b0, 3'd3, 32'h00, 32'h0, 32'h0, 1'b1, 1});
    tbl.push_back('{1'b0, 3'd6, 32'h04, 32'h0, 32'h0, 1'b1, 1});
    tbl.push_back('{1'b1, 3'd4, 32'h04, 32'h0, 32'h0, 1'b1, 1});
    tbl.push_back('{1'b1, 3'd2, 32'hFC, 32'hCAFEF00D, 32'h0, 1'b0, 2});
    tbl.push_back('{1'b0, 3'd1, 32'hFE, 32'h0, 32'hFFFFCAFE, 1'b0, 2});
    tbl.push_back('{1'b1, 3'd0, 32'h100, 32'hAA, 32'h0, 1'b1, 1});

    foreach (tbl[i]) begin
      model(tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].d, erd, eer, elat, enw);
      do_req(tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].d, rd, er, lat, nw);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("tbl%0d_error", i), {31'd0, er}, {31'd0, tbl[i].er});
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_writes", i), nw, (tbl[i].w && !tbl[i].er) ? 1 : 0);
    end

    // Reset while the SB is in MERGE: no write, no response.
    model(1'b1, 3'd2, 32'h10, 32'h11223344, erd, eer, elat, enw);
    do_req(1'b1, 3'd2, 32'h10, 32'h11223344, rd, er, lat, nw);
    w0 = wr_count; r0 = rsp_count;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0; req_addr = 32'h10; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("merge_we_before_rst", {31'd0, mem_write_enable}, 32'd1);
    rst_n = 1'b0; #1;
    chk("merge_we_in_rst", {31'd0, mem_write_enable}, 32'd0);
    chk("merge_wdata_in_rst", mem_write_data, 32'd0);
    @(posedge clk); #1;
    chk("merge_rsp_in_rst", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("merge_ready_after", {31'd0, req_ready}, 32'd1);
    chk("merge_addr_after", mem_address, 32'd0);
    chk("merge_no_write", wr_count - w0, 32'd0);
    chk("merge_no_rsp", rsp_count - r0, 32'd0);
    model(1'b0, 3'd2, 32'h10, 32'h0, erd, eer, elat, enw);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat, nw);
    chk("merge_word_intact", rd, 32'h11223344);

    // A request held across a busy period is accepted once only.
    r0 = rsp_count;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
    repeat (2) @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("busy_ignored", rsp_count - r0, 32'd1);

    for (int n = 0; n < 300; n++) begin
      logic w; logic [2:0] f3; logic [31:0] a, d;
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 4 * WORDS + 15));
      d  = $urandom;
      model(w, f3, a, d, erd, eer, elat, enw);
      do_req(w, f3, a, d, rd, er, lat, nw);
      chk($sformatf("rnd%0d_rdata", n), rd, erd);
      chk($sformatf("rnd%0d_error", n), {31'd0, er}, {31'd0, eer});
      chk($sformatf("rnd%0d_latency", n), lat, elat);
      chk($sformatf("rnd%0d_writes", n), nw, enw);
    end

    bad = 0;
    for (int i = 0; i < WORDS; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_image", bad, 32'd0);
    chk("we_violations", viol, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
